// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32 x 64-bit CPU register file.
package regfile_pkg;
  localparam int WIDTH    = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage : regfile_pkg

// File: rtl/decoder5_32.sv
// 5:32 one-hot decoder; all outputs low when ena is low.
module decoder5_32 (
  input  logic        ena,
  input  logic [4:0]  sel,
  output logic [31:0] out
);
  // One-hot enable for the selected line, gated by ena
  always_comb begin
    out = '0;
    if (ena) out[sel] = 1'b1;
  end
endmodule : decoder5_32

// File: rtl/mux_32to1.sv
// 1-bit 32:1 multiplexer built as a tree: eight 4:1, two 4:1, one 2:1.
module mux_32to1 (
  input  logic [31:0] in,
  input  logic [4:0]  sel,
  output logic        out
);
  logic [7:0] lvl1;
  logic [1:0] lvl2;

  for (genvar g = 0; g < 8; g++) begin : g_lvl1
    assign lvl1[g] = sel[1] ? (sel[0] ? in[4*g+3] : in[4*g+2])
                            : (sel[0] ? in[4*g+1] : in[4*g]);
  end

  for (genvar g = 0; g < 2; g++) begin : g_lvl2
    assign lvl2[g] = sel[3] ? (sel[2] ? lvl1[4*g+3] : lvl1[4*g+2])
                            : (sel[2] ? lvl1[4*g+1] : lvl1[4*g]);
  end

  assign out = sel[4] ? lvl2[1] : lvl2[0];
endmodule : mux_32to1

// File: rtl/register.sv
// Generic storage register with synchronous active-high clear and write enable.
module register #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Hold unless written; clear takes priority over a write in the same cycle
  always_comb begin
    data_d = data_q;
    if (reset)     data_d = '0;
    else if (we_i) data_d = d_i;
  end

  // State update on the clock edge
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q_o = data_q;
endmodule : register

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: one write port, two combinational read ports.
// X31 has no storage; its mux input is tied low so it always reads zero
// and writes to it are simply dropped.
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      RegWrite,
  input  reg_addr_t WriteRegister,
  input  word_t     WriteData,
  input  reg_addr_t ReadRegister1,
  input  reg_addr_t ReadRegister2,
  output word_t     ReadData1,
  output word_t     ReadData2
);
  logic [NUM_REGS-1:0] wr_en;
  word_t               reg_q [ZERO_REG];
  logic [NUM_REGS-1:0] col [WIDTH];
  logic                unused_zero_en;

  decoder5_32 u_dec (
    .ena (RegWrite),
    .sel (WriteRegister),
    .out (wr_en)
  );

  // The decoder line for X31 has nothing to enable
  assign unused_zero_en = wr_en[ZERO_REG];

  for (genvar r = 0; r < ZERO_REG; r++) begin : g_regs
    register #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .we_i  (wr_en[r]),
      .d_i   (WriteData),
      .q_o   (reg_q[r])
    );
  end

  // Transpose storage into per-bit columns feeding the read muxes
  for (genvar b = 0; b < WIDTH; b++) begin : g_bits
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
      if (r == ZERO_REG) begin : g_zero
        assign col[b][r] = 1'b0;
      end else begin : g_live
        assign col[b][r] = reg_q[r][b];
      end
    end

    mux_32to1 u_rd1 (
      .in  (col[b]),
      .sel (ReadRegister1),
      .out (ReadData1[b])
    );

    mux_32to1 u_rd2 (
      .in  (col[b]),
      .sel (ReadRegister2),
      .out (ReadData2[b])
    );
  end
endmodule : regfile_32x64
